// File: rtl/fibo_host_ctrl.sv
// fibo_host_ctrl: host-side controller that hands one argument at a time to an
// ap_ctrl_hs callee, waits for its completion (bounded by a cycle timeout) and
// presents the result, or a timeout error, to the host through a valid/ready
// response channel. It also counts the responses the host has accepted.
module fibo_host_ctrl #(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_n,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              callee_ap_start,
   output logic [DATA_W-1:0] callee_n,
   input  logic              callee_ap_done,
   input  logic              callee_ap_ready,
   input  logic [DATA_W-1:0] callee_ap_return,
   output logic              busy,
   output logic [CNT_W-1:0]  done_count
);

   // TIMEOUT_CYC >= 2, so the last timer value always fits in this width
   localparam int TIMER_W = $clog2(TIMEOUT_CYC);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] timer;

   // Handshake outputs are pure decodes of the state register, so no input
   // ever reaches an output combinationally.
   assign req_ready       = (state == IDLE);
   assign callee_ap_start = (state == ISSUE);
   assign resp_valid      = (state == RESP);
   assign busy            = (state != IDLE);

   // Job sequencing: accept, start the callee, wait for done or timeout, respond
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state      <= IDLE;
         timer      <= '0;
         callee_n   <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         done_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  callee_n <= req_n;
                  timer    <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               // done is checked first so a completion on the final timer
               // cycle is reported as a result, not as a timeout
               if (callee_ap_done) begin
                  resp_data <= callee_ap_return;
                  resp_err  <= 1'b0;
                  state     <= RESP;
               end else if (timer == TIMER_LAST) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= RESP;
               end else begin
                  if (timer != '1) begin
                     timer <= timer + 1'b1;
                  end
                  if ((state == ISSUE) && callee_ap_ready) begin
                     state <= WAIT;
                  end
               end
            end
            RESP: begin
               // a stray callee done here is deliberately ignored
               if (resp_ready) begin
                  done_count <= done_count + 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fibo_host_ctrl.sv
// Bench for fibo_host_ctrl: two instances (long and short timeout) driven by a
// behavioural callee whose ready/done delays are chosen per job; each job's
// expected outcome is worked out from the timeout rule with plain arithmetic.
module tb_fibo_host_ctrl;
   localparam int DW   = 32;
   localparam int TO_A = 32;
   localparam int TO_B = 8;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic          ap_rst;
   logic [1:0]    req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic [1:0]    start, done, ready, busy;
   logic [DW-1:0] req_n [2];
   logic [DW-1:0] resp_data [2];
   logic [DW-1:0] callee_n [2];
   logic [DW-1:0] ret [2];
   logic [1:0]    done_count [2];

   int checks = 0;
   int errors = 0;
   int cnt [2];
   int timeout_of [2];

   fibo_host_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO_A), .CNT_W(2)) dut_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_n(req_n[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_data(resp_data[0]), .resp_err(resp_err[0]),
      .callee_ap_start(start[0]), .callee_n(callee_n[0]),
      .callee_ap_done(done[0]), .callee_ap_ready(ready[0]),
      .callee_ap_return(ret[0]), .busy(busy[0]), .done_count(done_count[0])
   );

   fibo_host_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO_B), .CNT_W(2)) dut_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_n(req_n[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_data(resp_data[1]), .resp_err(resp_err[1]),
      .callee_ap_start(start[1]), .callee_n(callee_n[1]),
      .callee_ap_done(done[1]), .callee_ap_ready(ready[1]),
      .callee_ap_return(ret[1]), .busy(busy[1]), .done_count(done_count[1])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
      end
   endtask

   // One job on unit s: callee raises ready in start-cycle r and done in
   // cycle d (counting the first start cycle as 0); host holds off for 'hold'.
   task automatic run_job(input int s, input logic [DW-1:0] n, input int r, input int d,
                          input logic [DW-1:0] rv, input int hold);
      bit            tmo;
      int            last;
      logic [DW-1:0] want_data;
      tmo       = (d > timeout_of[s] - 1);
      last      = tmo ? timeout_of[s] - 1 : d;
      want_data = tmo ? '0 : rv;
      check($sformatf("u%0d idle_req_ready", s), req_ready[s], 1'b1);
      check($sformatf("u%0d idle_busy", s), busy[s], 1'b0);
      req_valid[s] = 1'b1;
      req_n[s]     = n;
      @(negedge ap_clk);
      req_valid[s] = 1'b0;
      req_n[s]     = $urandom;
      for (int k = 0; k <= last; k++) begin
         check($sformatf("u%0d start k=%0d", s, k), start[s], (k <= r));
         check($sformatf("u%0d callee_n k=%0d", s, k), callee_n[s], n);
         if (k == 0) begin
            check($sformatf("u%0d run_req_ready", s), req_ready[s], 1'b0);
            check($sformatf("u%0d run_busy", s), busy[s], 1'b1);
            check($sformatf("u%0d run_resp_valid", s), resp_valid[s], 1'b0);
         end
         ready[s] = (k == r);
         done[s]  = (k == d);
         ret[s]   = (k == d) ? rv : DW'($urandom);
         @(negedge ap_clk);
      end
      ready[s] = 1'b0;
      done[s]  = 1'b0;
      check($sformatf("u%0d resp_valid", s), resp_valid[s], 1'b1);
      check($sformatf("u%0d resp_data", s), resp_data[s], want_data);
      check($sformatf("u%0d resp_err", s), resp_err[s], tmo);
      check($sformatf("u%0d resp_start", s), start[s], 1'b0);
      for (int h = 0; h < hold; h++) begin
         req_valid[s] = 1'b1;
         done[s]      = 1'($urandom_range(0, 1));
         ret[s]       = DW'($urandom);
         @(negedge ap_clk);
         check($sformatf("u%0d hold_valid h=%0d", s, h), resp_valid[s], 1'b1);
         check($sformatf("u%0d hold_data h=%0d", s, h), resp_data[s], want_data);
         check($sformatf("u%0d hold_err h=%0d", s, h), resp_err[s], tmo);
         check($sformatf("u%0d hold_req_ready h=%0d", s, h), req_ready[s], 1'b0);
      end
      done[s]       = 1'b0;
      req_valid[s]  = 1'b0;
      resp_ready[s] = 1'b1;
      @(negedge ap_clk);
      resp_ready[s] = 1'b0;
      cnt[s]++;
      check($sformatf("u%0d after_resp_valid", s), resp_valid[s], 1'b0);
      check($sformatf("u%0d after_req_ready", s), req_ready[s], 1'b1);
      check($sformatf("u%0d done_count", s), done_count[s], 64'(cnt[s] % 4));
   endtask

   initial begin
      timeout_of[0] = TO_A;
      timeout_of[1] = TO_B;
      cnt[0] = 0;
      cnt[1] = 0;
      ap_rst     = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      done       = '0;
      ready      = '0;
      for (int s = 0; s < 2; s++) begin
         req_n[s] = '0;
         ret[s]   = '0;
      end

      // reset state on both units
      @(negedge ap_clk);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("u%0d rst_busy", s), busy[s], 1'b0);
         check($sformatf("u%0d rst_start", s), start[s], 1'b0);
         check($sformatf("u%0d rst_resp_valid", s), resp_valid[s], 1'b0);
         check($sformatf("u%0d rst_resp_err", s), resp_err[s], 1'b0);
         check($sformatf("u%0d rst_resp_data", s), resp_data[s], 0);
         check($sformatf("u%0d rst_callee_n", s), callee_n[s], 0);
         check($sformatf("u%0d rst_done_count", s), done_count[s], 0);
      end
      ap_rst = 1'b0;
      @(negedge ap_clk);

      // ready and done together, 5 cycles after start
      run_job(0, 10, 5, 5, 55, 0);
      // ready one cycle after start, done 20 cycles after that
      run_job(0, 17, 1, 21, 32'h1234, 0);
      // host stalls the response for 10 cycles
      run_job(0, 5, 2, 4, 5, 10);

      // short-timeout unit: callee never finishes
      run_job(1, 9, 0, 100000, 32'hdead, 2);
      // a stray done after the timeout must not produce a response
      for (int k = 0; k < 3; k++) begin
         done[1] = 1'b1;
         ret[1]  = DW'($urandom);
         @(negedge ap_clk);
         check($sformatf("u1 stray_valid k=%0d", k), resp_valid[1], 1'b0);
         check($sformatf("u1 stray_busy k=%0d", k), busy[1], 1'b0);
      end
      done[1] = 1'b0;
      @(negedge ap_clk);
      // done on the final timer cycle wins; one cycle later is a timeout
      run_job(1, 4, 0, TO_B - 1, 32'h77, 0);
      run_job(1, 6, 3, TO_B, 32'h88, 1);

      // asynchronous reset in the middle of a WAIT
      req_valid[0] = 1'b1;
      req_n[0]     = 7;
      @(negedge ap_clk);
      req_valid[0] = 1'b0;
      ready[0]     = 1'b1;
      @(negedge ap_clk);
      ready[0] = 1'b0;
      repeat (3) @(negedge ap_clk);
      check("u0 pre_rst_busy", busy[0], 1'b1);
      #2 ap_rst = 1'b1;
      #1;
      check("u0 async_busy", busy[0], 1'b0);
      check("u0 async_start", start[0], 1'b0);
      check("u0 async_resp_valid", resp_valid[0], 1'b0);
      check("u0 async_callee_n", callee_n[0], 0);
      check("u0 async_done_count", done_count[0], 0);
      check("u0 async_resp_data", resp_data[0], 0);
      cnt[0] = 0;
      cnt[1] = 0;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("u0 post_rst_resp_valid", resp_valid[0], 1'b0);
      run_job(0, 3, 2, 6, 2, 0);

      // back-to-back jobs: a 2-bit counter wraps 2,3,0,1,2 from here
      for (int j = 0; j < 5; j++) begin
         run_job(0, DW'(j + 1), 0, j, DW'($urandom), 0);
      end

      // randomized jobs on both units, some finishing past the timeout
      for (int j = 0; j < 24; j++) begin
         int s, r, d;
         s = j % 2;
         r = $urandom_range(0, 3);
         d = r + $urandom_range(0, timeout_of[s] + 4);
         run_job(s, DW'($urandom), r, d, DW'($urandom), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fibo_host_ctrl.md
FIBO_HOST_CTRL -- requirements
Module: fibo_host_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of argument and result words.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, max cycles from start issue to callee done; legal range 2..65535.
REQ-003 SHALL have parameter CNT_W, default 16, width of completed-job counter.
REQ-004 ap_clk  input  1  sole clock, rising edge.
REQ-005 ap_rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block can accept request.
REQ-008 req_n  input  DATA_W  argument for callee.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  host accepts result.
REQ-011 resp_data  output  DATA_W  captured callee return, or 0 on error.
REQ-012 resp_err  output  1  result is a timeout, qualified by resp_valid.
REQ-013 callee_ap_start  output  1  ap_ctrl_hs start to callee.
REQ-014 callee_n  output  DATA_W  argument to callee, held stable from issue until done or timeout.
REQ-015 callee_ap_done  input  1  callee completion pulse.
REQ-016 callee_ap_ready  input  1  callee consumed start.
REQ-017 callee_ap_return  input  DATA_W  callee result, valid in the callee_ap_done cycle only.
REQ-018 busy  output  1  state is not IDLE.
REQ-019 done_count  output  CNT_W  number of responses accepted by host.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, one-hot or binary, fully registered.
REQ-021 IDLE: req_ready=1; on req_valid&req_ready, register req_n into callee_n, clear timer, go ISSUE next cycle.
REQ-022 ISSUE: callee_ap_start=1; stays until callee_ap_ready sampled 1.
REQ-023 ISSUE with callee_ap_ready=1 and callee_ap_done=0 -> WAIT, callee_ap_start deasserts next cycle.
REQ-024 ISSUE or WAIT with callee_ap_done=1 -> capture callee_ap_return into resp_data, resp_err=0, go RESP; done in the same cycle as ready SHALL be handled (callee asserts ready and done together).
REQ-025 WAIT: callee_ap_start=0; waits for callee_ap_done.
REQ-026 Timer increments each cycle in ISSUE/WAIT, saturating; when timer == TIMEOUT_CYC-1 and callee_ap_done=0 -> resp_data=0, resp_err=1, callee_ap_start=0, go RESP.
REQ-027 Simultaneous done and timeout: done wins, resp_err=0.
REQ-028 RESP: resp_valid=1, resp_data/resp_err stable; on resp_ready go IDLE and increment done_count modulo 2^CNT_W (wraps to 0).
REQ-029 req_ready=0 in all states except IDLE; no request accepted same cycle as response handshake (minimum one IDLE cycle between jobs).
REQ-030 callee_ap_done outside ISSUE/WAIT SHALL be ignored (stale done after timeout never produces a response).
REQ-031 Latency: accept at edge T -> callee_ap_start high T+1; done sampled at edge D -> resp_valid high after D.
REQ-032 All outputs SHALL be driven from registers or from the state register only; no combinational path from inputs to outputs.

Reset
REQ-033 ap_rst=1 SHALL immediately force state IDLE, callee_ap_start=0, resp_valid=0, resp_err=0, resp_data=0, callee_n=0, timer=0, done_count=0, busy=0; req_ready=1 after release.
REQ-034 Reset mid-job SHALL abandon the job with no response; first edge after release is IDLE behaviour.

Verification
REQ-035 req_n=10, callee model ready+done together 5 cycles after start, return=55 -> resp_valid with resp_data=55, resp_err=0; done_count=1 after resp_ready.
REQ-036 Callee ready 1 cycle after start, done 20 cycles later with return=0x1234 -> state WAIT, callee_ap_start low after ready, resp_data=0x1234.
REQ-037 TIMEOUT_CYC=8, callee never done -> resp_valid after 8 cycles in ISSUE/WAIT, resp_err=1, resp_data=0; later stray done ignored, no second response.
REQ-038 resp_ready held 0 for 10 cycles -> resp_valid/resp_data stable, req_ready=0, new req_valid not accepted.
REQ-039 ap_rst asserted while in WAIT -> outputs reset asynchronously before next edge; subsequent req_n=3 completes normally.
REQ-040 CNT_W=2, five back-to-back jobs -> done_count sequence 1,2,3,0,1.
